// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// fixed timing constants and common keyboard command bytes.
package ps2_host_tx_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_SEND,
      ST_STOP,
      ST_ACK,
      ST_WAIT_IDLE,
      ST_DONE,
      ST_FAIL
   } ps2_tx_state_t;

   localparam int unsigned RTS_HOLD_CYCLES    = 100;
   localparam int unsigned PS2_TX_MAX_RETRIES = 2;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

   // PS/2 frames carry odd parity over the eight data bits
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the game logic (master) and the PS/2 transmitter (slave).
interface ps2_host_tx_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_error;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  tx_done,
      input  tx_error
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output tx_done,
      output tx_error
   );

endinterface

// File: rtl/ps2_host_tx_sync_edge.sv
// Two-flop synchronizer for a PS/2 pad with a falling-edge strobe (prev=1, cur=0).
module ps2_sync_edge (
   input  logic clk_100MHz,
   input  logic sw_rst_n,
   input  logic pad,
   output logic level,
   output logic fall
);

   logic meta;
   logic prev;

   // Idle PS/2 lines float high, so reset to 1 to avoid a phantom edge
   always_ff @(posedge clk_100MHz or negedge sw_rst_n) begin
      if (!sw_rst_n) begin
         meta  <= 1'b1;
         level <= 1'b1;
         prev  <= 1'b1;
      end else begin
         meta  <= pad;
         level <= meta;
         prev  <= level;
      end
   end

   assign fall = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain clock/data pads.
// Build option: define PS2_TX_RETRY_EN to retry a NACKed/timed-out byte twice.
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 12000,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic         clk_100MHz,
   input  logic         sw_rst_n,
   ps2_host_tx_if.slave host,
   input  logic         ps2_clk_in,
   input  logic         ps2_data_in,
   output logic         ps2_clk_oe,
   output logic         ps2_data_oe,
   inout  wire          ps2_clk,
   inout  wire          ps2_data
);

   localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > RTS_HOLD_CYCLES) ?
                                     INHIBIT_CYCLES : RTS_HOLD_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);

   ps2_tx_state_t    state;
   logic [CNT_W-1:0] cnt;
   logic [TO_W-1:0]  to_cnt;
   logic [3:0]       bit_idx;
   logic [7:0]       data_q;
   logic             parity_q;
   logic             ready_q;
   logic             done_q;
   logic             error_q;
`ifdef PS2_TX_RETRY_EN
   logic [1:0]       retries;
`endif

   logic clk_level;
   logic clk_fall;
   logic data_level;
   logic data_fall_unused;

   logic to_active;
   logic to_hit;
   logic nack;
   logic attempt_failed;
   logic send_bit;

   ps2_sync_edge u_clk_sync (
      .clk_100MHz (clk_100MHz),
      .sw_rst_n   (sw_rst_n),
      .pad        (ps2_clk_in),
      .level      (clk_level),
      .fall       (clk_fall)
   );

   ps2_sync_edge u_data_sync (
      .clk_100MHz (clk_100MHz),
      .sw_rst_n   (sw_rst_n),
      .pad        (ps2_data_in),
      .level      (data_level),
      .fall       (data_fall_unused)
   );

   always_comb begin
      to_active = 1'b0;
      unique case (state)
         ST_SEND, ST_STOP, ST_ACK, ST_WAIT_IDLE: to_active = 1'b1;
         default:                                to_active = 1'b0;
      endcase
      to_hit         = to_active && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
      nack           = (state == ST_ACK) && clk_fall && data_level;
      attempt_failed = to_hit || nack;
      send_bit       = (bit_idx == 4'd8) ? parity_q : data_q[bit_idx[2:0]];
   end

   always_ff @(posedge clk_100MHz or negedge sw_rst_n) begin
      if (!sw_rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         to_cnt      <= '0;
         bit_idx     <= '0;
         data_q      <= '0;
         parity_q    <= 1'b0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         retries     <= '0;
`endif
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         if (to_active) begin
            to_cnt <= to_cnt + 1'b1;
         end

         // Failure handling overrides the per-state transitions below
         if (attempt_failed) begin
`ifdef PS2_TX_RETRY_EN
            if (retries != 2'(PS2_TX_MAX_RETRIES)) begin
               retries     <= retries + 1'b1;
               state       <= ST_INHIBIT;
               cnt         <= '0;
               ps2_clk_oe  <= 1'b1;
               ps2_data_oe <= 1'b0;
            end else begin
               state       <= ST_FAIL;
               error_q     <= 1'b1;
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
            end
`else
            state       <= ST_FAIL;
            error_q     <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
`endif
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (host.tx_valid) begin
                     data_q     <= host.tx_data;
                     parity_q   <= odd_parity(host.tx_data);
                     cnt        <= '0;
                     ready_q    <= 1'b0;
                     ps2_clk_oe <= 1'b1;
                     state      <= ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                     retries    <= '0;
`endif
                  end
               end
               ST_INHIBIT: begin
                  if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                     cnt         <= '0;
                     ps2_data_oe <= 1'b1;
                     state       <= ST_RTS;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_RTS: begin
                  if (cnt == CNT_W'(RTS_HOLD_CYCLES - 1)) begin
                     cnt        <= '0;
                     to_cnt     <= '0;
                     bit_idx    <= '0;
                     ps2_clk_oe <= 1'b0;
                     state      <= ST_SEND;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_SEND: begin
                  if (clk_fall) begin
                     ps2_data_oe <= ~send_bit;
                     bit_idx     <= bit_idx + 1'b1;
                     if (bit_idx == 4'd8) begin
                        state <= ST_STOP;
                     end
                  end
               end
               ST_STOP: begin
                  if (clk_fall) begin
                     ps2_data_oe <= 1'b0;
                     state       <= ST_ACK;
                  end
               end
               ST_ACK: begin
                  if (clk_fall) begin
                     state <= ST_WAIT_IDLE;
                  end
               end
               ST_WAIT_IDLE: begin
                  if (clk_level && data_level) begin
                     done_q <= 1'b1;
                     state  <= ST_DONE;
                  end
               end
               ST_DONE, ST_FAIL: begin
                  ready_q <= 1'b1;
                  state   <= ST_IDLE;
               end
               default: begin
                  ready_q     <= 1'b1;
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  state       <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign host.tx_ready = ready_q;
   assign host.tx_done  = done_q;
   assign host.tx_error = error_q;

   assign ps2_clk  = ps2_clk_oe  ? 1'b0 : 1'bz;
   assign ps2_data = ps2_data_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a bit-level PS/2 device model.
module tb_ps2_host_tx;

   localparam int unsigned INHIBIT = 200;
   localparam int unsigned TIMEOUT = 1000;
   localparam int          HALF    = 20;

   typedef struct {
      logic        is_done;
      logic        chk_frame;
      logic [10:0] frame;
   } exp_t;

   logic clk;
   logic rst_n;
   logic dev_clk;
   logic dev_data;
   logic pad_clk_in;
   logic pad_data_in;
   logic clk_oe;
   logic data_oe;
   wire  pad_clk;
   wire  pad_data;

   logic [10:0] dev_bits;
   int          total;
   int          bad;
   int          inhibit_cnt;
   logic        clk_oe_prev;
   exp_t        exp_q[$];

   ps2_host_tx_if bus ();

   ps2_host_tx #(
      .INHIBIT_CYCLES (INHIBIT),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk_100MHz  (clk),
      .sw_rst_n    (rst_n),
      .host        (bus),
      .ps2_clk_in  (pad_clk_in),
      .ps2_data_in (pad_data_in),
      .ps2_clk_oe  (clk_oe),
      .ps2_data_oe (data_oe),
      .ps2_clk     (pad_clk),
      .ps2_data    (pad_data)
   );

   // Wired-AND of host open-drain pull and device drive
   assign pad_clk_in  = dev_clk  & ~clk_oe;
   assign pad_data_in = dev_data & ~data_oe;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   always @(posedge clk) begin
      clk_oe_prev <= clk_oe;
      if (rst_n && clk_oe && !clk_oe_prev) inhibit_cnt++;
   end

   // Monitor: pops one expectation per done/error pulse
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && (bus.tx_done || bus.tx_error)) begin
         check("pulse_exclusive", {31'd0, bus.tx_done & bus.tx_error}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {30'd0, bus.tx_done, bus.tx_error}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("result_done", {31'd0, bus.tx_done}, {31'd0, e.is_done});
            check("result_error", {31'd0, bus.tx_error}, {31'd0, ~e.is_done});
            if (!e.is_done) check("oe_released", {30'd0, clk_oe, data_oe}, 32'd0);
            if (e.chk_frame) check("frame", {21'd0, dev_bits}, {21'd0, e.frame});
         end
      end
   end

   task automatic push(input logic is_done, input logic chk, input logic [7:0] b, input logic par);
      exp_t e;
      e.is_done   = is_done;
      e.chk_frame = chk;
      e.frame     = {1'b1, par, b, 1'b0};
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [7:0] b, input bit chk_tim);
      int n;
      @(posedge clk); #1;
      bus.tx_valid = 1'b1;
      bus.tx_data  = b;
      n = 0;
      while (!bus.tx_ready && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      bus.tx_valid = 1'b0;
      if (chk_tim) begin
         check("ready_falls", {31'd0, bus.tx_ready}, 32'd0);
         check("clk_oe_rises", {31'd0, clk_oe}, 32'd1);
         check("clk_pad_low", {31'd0, pad_clk}, 32'd0);
         n = 0;
         while (!data_oe && n < 5000) begin
            @(posedge clk); #1;
            n++;
         end
         check("inhibit_len", n, 32'd200);
         n = 0;
         while (clk_oe && n < 5000) begin
            @(posedge clk); #1;
            n++;
         end
         check("rts_len", n, 32'd100);
      end
   endtask

   task automatic device(input int n_edges, input bit nack, input bit chk_lat);
      int  g;
      bit  lat_pending;
      g = 0;
      dev_bits = '0;
      while (!(clk_oe == 1'b0 && data_oe == 1'b1) && g < 5000) begin
         @(posedge clk); #1;
         g++;
      end
      if (g >= 5000) begin
         check("rts_seen", 32'd0, 32'd1);
         return;
      end
      repeat (10) @(posedge clk);
      #1;
      dev_bits[0] = pad_data_in;
      lat_pending = chk_lat;
      for (int i = 1; i <= n_edges; i++) begin
         dev_clk = 1'b0;
         for (int c = 0; c < HALF; c++) begin
            @(posedge clk); #1;
            if (lat_pending && i == 1 && data_oe == 1'b0) begin
               check("edge_to_drive", c + 1, 32'd3);
               lat_pending = 1'b0;
            end
         end
         if (lat_pending) begin
            check("edge_to_drive_seen", 32'd0, 32'd1);
            lat_pending = 1'b0;
         end
         if (i <= 10) dev_bits[i] = pad_data_in;
         dev_clk = 1'b1;
         if (i == 10) dev_data = nack;
         if (i == 11) dev_data = 1'b1;
         repeat (HALF) @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_sb();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) check("scoreboard_drain", exp_q.size(), 32'd0);
      @(posedge clk); #1;
      check("ready_after", {31'd0, bus.tx_ready}, 32'd1);
   endtask

   initial begin
      int n;
      total       = 0;
      bad         = 0;
      inhibit_cnt = 0;
      rst_n       = 1'b0;
      dev_clk     = 1'b1;
      dev_data    = 1'b1;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      repeat (5) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, bus.tx_ready}, 32'd1);
      check("rst_oe", {30'd0, clk_oe, data_oe}, 32'd0);
      check("rst_done", {31'd0, bus.tx_done}, 32'd0);
      check("rst_error", {31'd0, bus.tx_error}, 32'd0);
      rst_n = 1'b1;

      // 0xED: six ones -> parity 1
      push(1'b1, 1'b1, 8'hED, 1'b1);
      send(8'hED, 1'b1);
      device(11, 1'b0, 1'b1);
      wait_sb();

      push(1'b1, 1'b1, 8'h00, 1'b1);
      send(8'h00, 1'b0);
      device(11, 1'b0, 1'b0);
      wait_sb();

      push(1'b1, 1'b1, 8'h01, 1'b0);
      send(8'h01, 1'b0);
      device(11, 1'b0, 1'b0);
      wait_sb();

`ifdef PS2_TX_RETRY_EN
      inhibit_cnt = 0;
      push(1'b1, 1'b1, 8'hFF, 1'b1);
      send(8'hFF, 1'b0);
      device(11, 1'b1, 1'b0);
      device(11, 1'b1, 1'b0);
      device(11, 1'b0, 1'b0);
      wait_sb();
      check("inhibit_phases", inhibit_cnt, 32'd3);
`else
      // NACK of 0xF4: five ones -> parity 0
      push(1'b0, 1'b1, 8'hF4, 1'b0);
      send(8'hF4, 1'b0);
      device(11, 1'b1, 1'b0);
      wait_sb();

      // Silent device: error 1000 cycles after clock release
      push(1'b0, 1'b0, 8'hFF, 1'b1);
      send(8'hFF, 1'b0);
      n = 0;
      while (clk_oe !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (clk_oe && n < 5000) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!bus.tx_error && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("timeout_cycles", n, 32'd1000);
      wait_sb();
`endif

      // Reset during D4 of 0x00 (pad held low by host)
      send(8'h00, 1'b0);
      device(5, 1'b0, 1'b0);
      check("d4_driven_low", {31'd0, data_oe}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_oe", {30'd0, clk_oe, data_oe}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_ready_after", {31'd0, bus.tx_ready}, 32'd1);
      repeat (20) @(posedge clk);
      #1;
      check("queue_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
